tx_pulse_fire: RTL and testbench
================================

TX_PULSE_FIRE -- requirements
Module: tx_pulse_fire

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of transmit channels.
REQ-002 Parameter DELAY_WIDTH, default 16: width of each per-channel fire delay, in clock cycles.
REQ-003 Parameter CYCLES_WIDTH, default 4: width of the burst-length field.
REQ-004 Parameter HALF_PERIOD, default 4: clock cycles per half-period of the bipolar pulse; legal values are 1 or more.
REQ-005 clk  input  1  sole clock; all logic updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to fire one transmit event; sampled only in IDLE.
REQ-008 delay  input  [DELAY_WIDTH-1:0] x [0:NUM_CHANNELS-1] (unpacked array)  per-channel fire delay in cycles.
REQ-009 num_cycles  input  CYCLES_WIDTH  number of full pulse periods per channel.
REQ-010 pulse_p  output  NUM_CHANNELS  per-channel positive-drive enable, registered.
REQ-011 pulse_n  output  NUM_CHANNELS  per-channel negative-drive enable, registered.
REQ-012 busy  output  1  high while a transmit event is in progress (FIRE state).
REQ-013 done  output  1  single-cycle completion strobe.

Function
REQ-014 FSM states SHALL be IDLE, FIRE and DONE.
REQ-015 IDLE, start=1: the block SHALL latch delay[] and num_cycles.
  - num_cycles != 0: next state FIRE.
  - num_cycles == 0: next state DONE; no pulses are emitted.
REQ-016 Changes to delay[] or num_cycles after the latch SHALL have no effect on the event in progress.
REQ-017 start SHALL be ignored in FIRE and DONE; no queuing.
REQ-018 Timer t SHALL be 0 in the first FIRE cycle and increment by 1 each FIRE cycle.
  - Width: DELAY_WIDTH+CYCLES_WIDTH+log2(2*HALF_PERIOD)+1 bits, so it never wraps before completion.
REQ-019 Channel c SHALL be active for t in [delay[c], delay[c] + 2*HALF_PERIOD*num_cycles - 1].
REQ-020 Within the active window, let k = t - delay[c]:
  - pulse_p[c]=1 when (k mod 2*HALF_PERIOD) < HALF_PERIOD.
  - pulse_n[c]=1 otherwise.
REQ-021 Outside its active window, pulse_p[c] and pulse_n[c] SHALL both be 0.
REQ-022 pulse_p[c] and pulse_n[c] SHALL never be 1 in the same cycle, including across phase transitions.
REQ-023 Pulse outputs SHALL be registered: the output value for timer value t is visible in the cycle in which the timer equals t.
REQ-024 Per-channel state SHALL be a delay countdown plus a phase/period counter; channels are independent, and equal delays yield identical waveforms.
REQ-025 FIRE SHALL move to DONE in the cycle after the last active cycle of the channel with the largest latched delay.
REQ-026 DONE SHALL last exactly one cycle: done=1, busy=0, all pulse outputs 0; next state IDLE.
REQ-027 busy SHALL be 1 exactly in FIRE cycles; done SHALL be 1 exactly in DONE cycles.
REQ-028 delay=0 on any channel SHALL be legal and means that channel fires in the first FIRE cycle.

Reset
REQ-029 reset=1 SHALL force IDLE and clear all timers and counters in the following cycle.
  - pulse_p=0, pulse_n=0, busy=0, done=0.
REQ-030 reset SHALL take priority over start and over any FIRE/DONE activity.
  - Reset mid-burst truncates all pulses immediately.
  - No done strobe is issued for the aborted event.
REQ-031 After reset deasserts, a start in the first IDLE cycle SHALL be accepted.

Verification
REQ-032 Single channel (HALF_PERIOD=2, delays {0,3,1,5}, num_cycles=2, start at cycle S):
  - busy from S+1.
  - ch0: pulse_p at t=0-1 and 4-5; pulse_n at t=2-3 and 6-7.
  - ch3: pulse_p at t=5-6 and 9-10; pulse_n at t=7-8 and 11-12.
  - done at t=13 only; busy low at t=13.
REQ-033 Zero burst (num_cycles=0, start): no pulses; done=1 in the cycle after start; busy stays 0.
REQ-034 Start while busy (second start pulse during FIRE of REQ-032): waveforms and done timing unchanged; exactly one done.
REQ-035 Reset mid-burst (reset at t=6 of REQ-032): all outputs 0 from the next cycle; no done; a new start then fires normally.
REQ-036 Input change after latch (delay[] changed to {9,9,9,9} one cycle after start): waveforms match the originally latched delays.
REQ-037 Exhaustive invariant check over randomized delays and num_cycles:
  - pulse_p & pulse_n == 0 on every cycle.
  - Per channel, active cycle count == 2*HALF_PERIOD*num_cycles.

Source files
------------

// File: rtl/tx_pulse_fire_if.sv
// tx_pulse_fire_if
// Groups the transmit-fire control and pulse-drive signals into one bundle.
//   i_start      : request to fire one transmit event
//   i_delay      : per-channel fire delay in clock cycles (unpacked array)
//   i_num_cycles : full bipolar pulse periods per channel
//   o_pulse_p    : per-channel positive-drive enable
//   o_pulse_n    : per-channel negative-drive enable
//   o_busy       : transmit event in progress
//   o_done       : single-cycle completion strobe
// master drives the request side; slave is the pulse generator.
interface tx_pulse_fire_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DELAY_WIDTH  = 16,
  parameter int CYCLES_WIDTH = 4
) ();
  logic                    i_start;
  logic [DELAY_WIDTH-1:0]  i_delay [NUM_CHANNELS];
  logic [CYCLES_WIDTH-1:0] i_num_cycles;
  logic [NUM_CHANNELS-1:0] o_pulse_p;
  logic [NUM_CHANNELS-1:0] o_pulse_n;
  logic                    o_busy;
  logic                    o_done;

  modport master (
    output i_start, i_delay, i_num_cycles,
    input  o_pulse_p, o_pulse_n, o_busy, o_done
  );

  modport slave (
    input  i_start, i_delay, i_num_cycles,
    output o_pulse_p, o_pulse_n, o_busy, o_done
  );
endinterface

// File: rtl/tx_pulse_fire.sv
// tx_pulse_fire
// Multi-channel bipolar transmit pulse generator. On start the per-channel
// delays and burst length are latched; each channel then waits its delay and
// emits num_cycles full periods (HALF_PERIOD cycles positive, HALF_PERIOD
// cycles negative). A done strobe follows the last active cycle of the
// channel with the largest delay.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : tx_pulse_fire_if.slave (start/delay/num_cycles in,
//             pulse_p/pulse_n/busy/done out)
//
// state  | meaning
// S_IDLE | waiting for start, inputs latched on start
// S_FIRE | timer running, channels emitting pulses
// S_DONE | one-cycle completion strobe
module tx_pulse_fire #(
  parameter int NUM_CHANNELS = 4,
  parameter int DELAY_WIDTH  = 16,
  parameter int CYCLES_WIDTH = 4,
  parameter int HALF_PERIOD  = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  tx_pulse_fire_if.slave bus
);
  localparam int TW = DELAY_WIDTH + CYCLES_WIDTH + $clog2(2*HALF_PERIOD) + 1;
  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int HW = CYCLES_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [TW-1:0]           r_timer, w_timer_nxt;
  logic [TW-1:0]           r_t_last, w_t_last_nxt;
  logic [TW-1:0]           w_max_dly;
  logic [DELAY_WIDTH-1:0]  r_wait [NUM_CHANNELS];
  logic [DELAY_WIDTH-1:0]  w_wait_nxt [NUM_CHANNELS];
  logic [PW-1:0]           r_phase [NUM_CHANNELS];
  logic [PW-1:0]           w_phase_nxt [NUM_CHANNELS];
  logic [HW-1:0]           r_halves [NUM_CHANNELS];
  logic [HW-1:0]           w_halves_nxt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_pol, w_pol_nxt;
  logic [NUM_CHANNELS-1:0] r_pulse_p, w_pulse_p_nxt;
  logic [NUM_CHANNELS-1:0] r_pulse_n, w_pulse_n_nxt;

  // Channel state describes the cycle being output: r_wait counts down the
  // remaining delay, r_halves counts half-periods still to emit, r_pol selects
  // the drive polarity. Pulse registers are loaded from the next-cycle state so
  // the output for timer value t appears while the timer equals t.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_t_last_nxt  = r_t_last;
    w_wait_nxt    = r_wait;
    w_phase_nxt   = r_phase;
    w_halves_nxt  = r_halves;
    w_pol_nxt     = r_pol;
    w_pulse_p_nxt = '0;
    w_pulse_n_nxt = '0;
    w_max_dly     = '0;

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (TW'(bus.i_delay[c]) > w_max_dly) w_max_dly = TW'(bus.i_delay[c]);
    end

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_timer_nxt  = '0;
          // last FIRE timer value: largest delay plus burst length minus one
          w_t_last_nxt = w_max_dly + TW'(2*HALF_PERIOD) * TW'(bus.i_num_cycles) - TW'(1);
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_wait_nxt[c]   = bus.i_delay[c];
            w_phase_nxt[c]  = '0;
            w_halves_nxt[c] = {bus.i_num_cycles, 1'b0};
            w_pol_nxt[c]    = 1'b0;
          end
          w_state_nxt = (bus.i_num_cycles != '0) ? S_FIRE : S_DONE;
        end
      end
      S_FIRE: begin
        w_timer_nxt = r_timer + TW'(1);
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (r_wait[c] != '0) begin
            w_wait_nxt[c] = r_wait[c] - DELAY_WIDTH'(1);
          end else if (r_halves[c] != '0) begin
            if (r_phase[c] == PW'(HALF_PERIOD-1)) begin
              w_phase_nxt[c]  = '0;
              w_pol_nxt[c]    = ~r_pol[c];
              w_halves_nxt[c] = r_halves[c] - HW'(1);
            end else begin
              w_phase_nxt[c] = r_phase[c] + PW'(1);
            end
          end
        end
        if (r_timer == r_t_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt == S_FIRE) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if ((w_wait_nxt[c] == '0) && (w_halves_nxt[c] != '0)) begin
          w_pulse_p_nxt[c] = ~w_pol_nxt[c];
          w_pulse_n_nxt[c] =  w_pol_nxt[c];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_t_last  <= '0;
      r_pol     <= '0;
      r_pulse_p <= '0;
      r_pulse_n <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_wait[c]   <= '0;
        r_phase[c]  <= '0;
        r_halves[c] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_t_last  <= w_t_last_nxt;
      r_pol     <= w_pol_nxt;
      r_pulse_p <= w_pulse_p_nxt;
      r_pulse_n <= w_pulse_n_nxt;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_wait[c]   <= w_wait_nxt[c];
        r_phase[c]  <= w_phase_nxt[c];
        r_halves[c] <= w_halves_nxt[c];
      end
    end
  end

  assign bus.o_pulse_p = r_pulse_p;
  assign bus.o_pulse_n = r_pulse_n;
  assign bus.o_busy    = (r_state == S_FIRE);
  assign bus.o_done    = (r_state == S_DONE);
endmodule

// File: tb/tb_tx_pulse_fire.sv
module tb_tx_pulse_fire;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int HP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_pulse_fire_if #(.NUM_CHANNELS(NC), .DELAY_WIDTH(DW), .CYCLES_WIDTH(CW)) bus ();

  tx_pulse_fire #(
    .NUM_CHANNELS(NC), .DELAY_WIDTH(DW), .CYCLES_WIDTH(CW), .HALF_PERIOD(HP)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: event mode, timer and latched parameters; the pulse
  // waveform is computed directly from the window/phase arithmetic.
  int m_mode = 0;   // 0 idle, 1 fire, 2 done
  int m_t    = 0;
  int m_end  = 0;
  int m_n    = 0;
  int m_d [NC];
  int act_cnt [NC];

  function automatic int max_delay();
    int m = 0;
    for (int c = 0; c < NC; c++) if (int'(bus.i_delay[c]) > m) m = int'(bus.i_delay[c]);
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0;
    end else begin
      case (m_mode)
        0: if (bus.i_start) begin
          for (int c = 0; c < NC; c++) m_d[c] <= int'(bus.i_delay[c]);
          m_n    <= int'(bus.i_num_cycles);
          m_t    <= 0;
          m_end  <= max_delay() + 2*HP*int'(bus.i_num_cycles);
          m_mode <= (bus.i_num_cycles == '0) ? 2 : 1;
        end
        1: begin
          m_t <= m_t + 1;
          if (m_t + 1 == m_end) m_mode <= 2;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  function automatic logic [NC-1:0] exp_vec(input bit want_n);
    logic [NC-1:0] v = '0;
    int k;
    if (m_mode == 1) begin
      for (int c = 0; c < NC; c++) begin
        k = m_t - m_d[c];
        if (k >= 0 && k < 2*HP*m_n) v[c] = ((k % (2*HP)) < HP) ? ~want_n : want_n;
      end
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("pulse_p", bus.o_pulse_p, exp_vec(1'b0));
      check("pulse_n", bus.o_pulse_n, exp_vec(1'b1));
      check("busy", bus.o_busy, (m_mode == 1));
      check("done", bus.o_done, (m_mode == 2));
      check("p_n_overlap", bus.o_pulse_p & bus.o_pulse_n, 0);
      if (m_mode == 2)
        for (int c = 0; c < NC; c++) check("active_count", act_cnt[c], 2*HP*m_n);
      for (int c = 0; c < NC; c++)
        act_cnt[c] <= (m_mode == 1) ? act_cnt[c] + int'(bus.o_pulse_p[c]) + int'(bus.o_pulse_n[c]) : 0;
    end
  end

  // Reference event: delays {0,3,1,5}, two periods. Variants:
  // 0 plain, 1 extra start while busy, 2 delays changed after latch,
  // 3 reset at t=6 (returns with reset released, ready for an immediate start).
  task automatic fire_ref(input int variant);
    logic [13:0] lp0 = 14'h0033;
    logic [13:0] ln0 = 14'h00CC;
    logic [13:0] lp3 = 14'h0660;
    logic [13:0] ln3 = 14'h1980;
    logic [13:0] lb  = 14'h1FFF;
    logic [13:0] ld  = 14'h2000;
    bus.i_delay[0] = 16'd0; bus.i_delay[1] = 16'd3;
    bus.i_delay[2] = 16'd1; bus.i_delay[3] = 16'd5;
    bus.i_num_cycles = 4'd2;
    bus.i_start = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (t == 0) bus.i_start = 1'b0;
      if (variant == 3 && t >= 7) begin
        check("rst_abort_busy", bus.o_busy, 0);
        check("rst_abort_done", bus.o_done, 0);
        check("rst_abort_p", bus.o_pulse_p, 0);
        check("rst_abort_n", bus.o_pulse_n, 0);
        rst = 1'b0;
        break;
      end
      check("lit_p0", bus.o_pulse_p[0], (t < 14) ? lp0[t] : 1'b0);
      check("lit_n0", bus.o_pulse_n[0], (t < 14) ? ln0[t] : 1'b0);
      check("lit_p3", bus.o_pulse_p[3], (t < 14) ? lp3[t] : 1'b0);
      check("lit_n3", bus.o_pulse_n[3], (t < 14) ? ln3[t] : 1'b0);
      check("lit_busy", bus.o_busy, (t < 14) ? lb[t] : 1'b0);
      check("lit_done", bus.o_done, (t < 14) ? ld[t] : 1'b0);
      if (variant == 1 && t == 3) bus.i_start = 1'b1;
      if (variant == 1 && t == 4) bus.i_start = 1'b0;
      if (variant == 2 && t == 0)
        for (int c = 0; c < NC; c++) bus.i_delay[c] = 16'd9;
      if (variant == 3 && t == 6) rst = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_num_cycles = '0;
    for (int c = 0; c < NC; c++) bus.i_delay[c] = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.o_busy, 0);
    check("reset_done", bus.o_done, 0);
    check("reset_p", bus.o_pulse_p, 0);
    check("reset_n", bus.o_pulse_n, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // start in the first IDLE cycle after reset release
    fire_ref(0);
    fire_ref(1);
    fire_ref(2);
    fire_ref(3);
    fire_ref(0);

    // zero-length burst
    bus.i_num_cycles = 4'd0;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("zero_done", bus.o_done, 1);
    check("zero_busy", bus.o_busy, 0);
    check("zero_p", bus.o_pulse_p, 0);
    @(negedge clk);
    check("zero_done_after", bus.o_done, 0);
    check("zero_busy_after", bus.o_busy, 0);

    // randomized events, checked by the model every cycle
    for (int i = 0; i < 25; i++) begin
      int w;
      for (int c = 0; c < NC; c++) bus.i_delay[c] = 16'($urandom_range(0, 20));
      if (i == 3) for (int c = 0; c < NC; c++) bus.i_delay[c] = 16'd7;
      bus.i_num_cycles = 4'($urandom_range(0, 5));
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      w = 0;
      while (bus.o_done !== 1'b1 && w < 300) begin
        @(negedge clk);
        w++;
      end
      check("rand_done_seen", bus.o_done, 1);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
